// File: rtl/game_flow_ctrl.sv
// Game-flow state machine for the Doodle Jump top level: lives, respawn, pause,
// edge-qualified key commands and a frame-counted fall-out delay.
module game_flow_ctrl #(
  parameter int unsigned NUM_LIVES   = 3,
  parameter int unsigned DROP_FRAMES = 50,
  parameter logic [7:0]  KEY_START   = 8'd40,
  parameter logic [7:0]  KEY_PAUSE   = 8'd44
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  input  logic        death,
  input  logic        drop,
  output logic [2:0]  show,
  output logic        restart,
  output logic        respawn,
  output logic [3:0]  lives,
  output logic        playing
);

  localparam int unsigned LIVES_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_PLAY    = 3'd1;
  localparam logic [2:0] S_PAUSE   = 3'd2;
  localparam logic [2:0] S_DROP    = 3'd3;
  localparam logic [2:0] S_LOSE    = 3'd4;
  localparam logic [2:0] S_RESPAWN = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [2:0] SHOW_NONE  = 3'd0;
  localparam logic [2:0] SHOW_TITLE = 3'd1;
  localparam logic [2:0] SHOW_PAUSE = 3'd2;
  localparam logic [2:0] SHOW_OVER  = 3'd3;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DROP_FRAMES - 1);

  logic [2:0]         state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_s_q, frame_s_d;
  logic               frame_prev_q, frame_prev_d;
  logic [7:0]         key_prev_q, key_prev_d;

  logic       frame_tick_c;
  logic       start_hit_c;
  logic       pause_hit_c;
  logic [7:0] key_lo_c;
  logic       unused_key_hi;

  assign key_lo_c      = keycode[7:0];
  assign unused_key_hi = ^keycode[15:8];

  // Edge qualifiers: frame rising edge and key press (not hold) detection
  assign frame_tick_c = frame_s_q & ~frame_prev_q;
  assign start_hit_c  = (key_lo_c == KEY_START) && (key_prev_q != KEY_START);
  assign pause_hit_c  = (key_lo_c == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    cnt_d        = '0;
    frame_s_d    = frame_clk;
    frame_prev_d = frame_s_q;
    key_prev_d   = key_lo_c;

    case (state_q)
      S_START: begin
        if (start_hit_c) begin
          lives_d = LIVES_INIT;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (death)            state_d = S_LOSE;
        else if (drop)        state_d = S_DROP;
        else if (pause_hit_c) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_hit_c) state_d = S_PLAY;
      end
      S_DROP: begin
        cnt_d = cnt_q;
        if (frame_tick_c) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_LOSE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LOSE: begin
        if (lives_q > LIVES_W'(1)) begin
          lives_d = lives_q - LIVES_W'(1);
          state_d = S_RESPAWN;
        end else begin
          lives_d = '0;
          state_d = S_OVER;
        end
      end
      S_RESPAWN: state_d = S_PLAY;
      S_OVER: begin
        if (start_hit_c) state_d = S_HALT;
      end
      S_HALT: begin
        // Wait for the still-held Enter to be released before re-arming START
        if (key_lo_c == 8'd0) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_START;
      lives_q      <= LIVES_INIT;
      cnt_q        <= '0;
      frame_s_q    <= 1'b0;
      frame_prev_q <= 1'b0;
      key_prev_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      frame_s_q    <= frame_s_d;
      frame_prev_q <= frame_prev_d;
      key_prev_q   <= key_prev_d;
    end
  end

  // Moore output decode
  always_comb begin
    show    = SHOW_NONE;
    restart = 1'b0;
    respawn = 1'b0;
    playing = 1'b0;
    case (state_q)
      S_START: begin
        show    = SHOW_TITLE;
        restart = 1'b1;
      end
      S_PLAY:    playing = 1'b1;
      S_PAUSE:   show    = SHOW_PAUSE;
      S_RESPAWN: respawn = 1'b1;
      S_OVER:    show    = SHOW_OVER;
      S_HALT:    show    = SHOW_TITLE;
      default:   show    = SHOW_NONE;
    endcase
  end

  assign lives = lives_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [15:0] keycode;
  logic        death;
  logic        drop;
  logic [2:0]  show;
  logic        restart;
  logic        respawn;
  logic [3:0]  lives;
  logic        playing;

  int total = 0;
  int bad   = 0;

  game_flow_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .death(death), .drop(drop), .show(show), .restart(restart),
    .respawn(respawn), .lives(lives), .playing(playing)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1; step(); step();
    frame_clk = 1'b0; step(); step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; keycode = 16'd0; death = 1'b0; drop = 1'b0;
    step(); step();
    total++; if (show !== 3'd1) begin bad++; $display("FAIL reset_show got=%0d exp=1", show); end
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL reset_restart got=%0b exp=1", restart); end
    total++; if (lives !== 4'd3) begin bad++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    total++; if (playing !== 1'b0 || respawn !== 1'b0) begin bad++; $display("FAIL reset_play_resp got=%0b%0b exp=00", playing, respawn); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_start();
    int ok = 1;
    keycode = 16'd40;
    step();
    total++; if (show !== 3'd0 || playing !== 1'b1) begin bad++; $display("FAIL start_enter got show=%0d play=%0b exp 0/1", show, playing); end
    for (int i = 0; i < 9; i++) begin
      step();
      if (playing !== 1'b1 || show !== 3'd0 || restart !== 1'b0) ok = 0;
    end
    total++; if (ok != 1) begin bad++; $display("FAIL start_hold got ok=%0d exp=1", ok); end
  endtask

  task automatic test_pause();
    int ok = 1;
    keycode = 16'd44;  // direct 40 -> 44 change must count as a pause press
    step();
    total++; if (show !== 3'd2 || playing !== 1'b0) begin bad++; $display("FAIL pause_enter got show=%0d play=%0b exp 2/0", show, playing); end
    for (int i = 0; i < 19; i++) begin
      step();
      if (show !== 3'd2) ok = 0;
    end
    total++; if (ok != 1) begin bad++; $display("FAIL pause_hold got ok=%0d exp=1", ok); end
    death = 1'b1; step(); death = 1'b0; step();
    total++; if (show !== 3'd2 || lives !== 4'd3) begin bad++; $display("FAIL pause_death got show=%0d lives=%0d exp 2/3", show, lives); end
    keycode = 16'd0; step();
    total++; if (show !== 3'd2) begin bad++; $display("FAIL pause_release got show=%0d exp=2", show); end
    keycode = 16'd44; step();
    total++; if (show !== 3'd0 || playing !== 1'b1) begin bad++; $display("FAIL pause_exit got show=%0d play=%0b exp 0/1", show, playing); end
    keycode = 16'd0; step();
  endtask

  // From PLAY: enter DROP and run the full fall-out delay to a respawn
  task automatic test_drop(input logic [3:0] exp_lives);
    int ok = 1;
    drop = 1'b1; step(); drop = 1'b0;
    total++; if (playing !== 1'b0 || show !== 3'd0 || respawn !== 1'b0) begin bad++; $display("FAIL drop_enter got play=%0b show=%0d exp 0/0", playing, show); end
    for (int i = 0; i < 49; i++) begin
      frame_pulse();
      if (playing !== 1'b0 || respawn !== 1'b0 || lives !== exp_lives) ok = 0;
    end
    total++; if (ok != 1) begin bad++; $display("FAIL drop_49_ticks got ok=%0d exp=1 lives=%0d", ok, lives); end
    frame_clk = 1'b1; step(); step();
    frame_clk = 1'b0;
    total++; if (respawn !== 1'b0 || lives !== exp_lives || playing !== 1'b0) begin bad++; $display("FAIL drop_lose got resp=%0b lives=%0d exp 0/%0d", respawn, lives, exp_lives); end
    step();
    total++; if (respawn !== 1'b1 || lives !== exp_lives - 4'd1) begin bad++; $display("FAIL drop_respawn got resp=%0b lives=%0d exp 1/%0d", respawn, lives, exp_lives - 4'd1); end
    step();
    total++; if (respawn !== 1'b0 || playing !== 1'b1) begin bad++; $display("FAIL drop_replay got resp=%0b play=%0b exp 0/1", respawn, playing); end
  endtask

  task automatic test_death_drop();
    // lives=2 -> respawn with 1
    death = 1'b1; drop = 1'b1; step(); death = 1'b0; drop = 1'b0;
    total++; if (playing !== 1'b0 || show !== 3'd0) begin bad++; $display("FAIL dd_lose got play=%0b show=%0d exp 0/0", playing, show); end
    step();
    total++; if (respawn !== 1'b1 || lives !== 4'd1) begin bad++; $display("FAIL dd_respawn got resp=%0b lives=%0d exp 1/1", respawn, lives); end
    step();
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL dd_replay got play=%0b exp=1", playing); end
    // last life: PLAY -> LOSE -> OVER in 2 Clk
    death = 1'b1; drop = 1'b1; step(); death = 1'b0; drop = 1'b0;
    total++; if (show !== 3'd0 || lives !== 4'd1) begin bad++; $display("FAIL dd_lose_last got show=%0d lives=%0d exp 0/1", show, lives); end
    step();
    total++; if (show !== 3'd3 || lives !== 4'd0 || respawn !== 1'b0) begin bad++; $display("FAIL dd_over got show=%0d lives=%0d exp 3/0", show, lives); end
    death = 1'b1; step(); step(); death = 1'b0; step();
    total++; if (show !== 3'd3 || lives !== 4'd0) begin bad++; $display("FAIL over_hold got show=%0d lives=%0d exp 3/0", show, lives); end
  endtask

  task automatic test_over_restart();
    keycode = 16'd40; step();
    total++; if (show !== 3'd1 || restart !== 1'b0) begin bad++; $display("FAIL halt_enter got show=%0d rst=%0b exp 1/0", show, restart); end
    step(); step();
    total++; if (show !== 3'd1 || restart !== 1'b0) begin bad++; $display("FAIL halt_hold got show=%0d rst=%0b exp 1/0", show, restart); end
    keycode = 16'd0; step();
    total++; if (show !== 3'd1 || restart !== 1'b1) begin bad++; $display("FAIL halt_start got show=%0d rst=%0b exp 1/1", show, restart); end
    keycode = 16'd40; step();
    total++; if (playing !== 1'b1 || lives !== 4'd3) begin bad++; $display("FAIL restart_play got play=%0b lives=%0d exp 1/3", playing, lives); end
    keycode = 16'd0; step();
  endtask

  task automatic test_reset_mid_drop();
    drop = 1'b1; step(); drop = 1'b0;
    for (int i = 0; i < 25; i++) frame_pulse();
    total++; if (playing !== 1'b0 || respawn !== 1'b0) begin bad++; $display("FAIL mid_drop got play=%0b resp=%0b exp 0/0", playing, respawn); end
    Reset = 1'b1; step(); Reset = 1'b0;
    total++; if (show !== 3'd1 || restart !== 1'b1 || lives !== 4'd3) begin bad++; $display("FAIL mid_drop_reset got show=%0d rst=%0b lives=%0d exp 1/1/3", show, restart, lives); end
    keycode = 16'd40; step(); keycode = 16'd0; step();
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL mid_drop_replay got play=%0b exp=1", playing); end
    test_drop(4'd3);
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_drop(4'd3);
    test_death_drop();
    test_over_restart();
    test_reset_mid_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
